ft245a_phy: RTL and testbench
=============================

// Module: ft245a_phy
// PURPOSE
//  Pin-level engine for the FT245 asynchronous FIFO interface, in the ft_clk domain.
//  Generates RD#/WR# strobes with programmable tick widths and bus turnaround.
//  Pushes received bytes to the RX FIFO write side and pops bytes from the TX FIFO
//  read side. It is the stage between the FT chip pins and proto245a's CDC FIFOs.
// PARAMETERS
//  DATA_W            8  data bus width
//  READ_TICKS        4  ft_clk cycles RD# held low per read (>=1)
//  WRITE_TICKS       4  ft_clk cycles WR# held low per write (>=1)
//  TURNAROUND_TICKS  8  ft_clk cycles with RD#/WR# high and bus released after each access (>=1)
// PORTS
//  ft_clk    in   1       clock
//  ft_rst    in   1       reset, asynchronous, active-low
//  ft_rxfn   in   1       FT has RX data when low (asynchronous to ft_clk)
//  ft_txen   in   1       FT can accept TX data when low (asynchronous to ft_clk)
//  ft_din    in   DATA_W  data bus input
//  ft_dout   out  DATA_W  data bus output
//  ft_oe     out  1       drive enable for ft_dout (1 = drive)
//  ft_rdn    out  1       read strobe, active-low
//  ft_wrn    out  1       write strobe, active-low
//  rx_data   out  DATA_W  received byte
//  rx_valid  out  1       1-cycle push strobe for rx_data
//  rx_ready  in   1       RX FIFO has >=1 free slot
//  tx_data   in   DATA_W  head of TX FIFO (show-ahead)
//  tx_valid  in   1       TX FIFO not empty
//  tx_rd     out  1       1-cycle pop strobe
// BEHAVIOUR
//  Reset values (asynchronous, while ft_rst=0):
//   - ft_rdn=1, ft_wrn=1, ft_oe=0, ft_dout=0, rx_data=0, rx_valid=0, tx_rd=0.
//   - State = IDLE; synchroniser flops = 1.
//   - Reset mid-access aborts the access immediately; no rx_valid and no tx_rd is issued.
//  Input sync: ft_rxfn and ft_txen pass through 2-flop synchronisers -> rxf_s, txe_s.
//  Request decode: rd_req = !rxf_s & rx_ready; wr_req = !txe_s & tx_valid.
//   Both are sampled only in IDLE.
//  FSM states: IDLE, READ, WRITE, TURN. A single tick counter is reloaded on every state entry.
//   IDLE:
//    - rd_req only -> READ.
//    - wr_req only -> WRITE.
//    - Both -> arbitration (see CONFIGURATION).
//    - Neither -> stay.
//   READ:
//    - ft_rdn=0 from the first cycle after leaving IDLE, for exactly READ_TICKS cycles.
//    - On the last low cycle ft_din is registered into rx_data.
//    - Next cycle: rx_valid=1 for one cycle, ft_rdn=1, state -> TURN.
//   WRITE:
//    - tx_rd=1 on the IDLE->WRITE transition cycle; tx_data is latched into ft_dout.
//    - ft_oe=1 on WRITE entry; ft_wrn=0 one cycle later (data setup) for WRITE_TICKS cycles.
//    - Then ft_wrn=1, ft_oe stays 1 one more cycle (data hold), state -> TURN.
//   TURN:
//    - ft_rdn=1, ft_wrn=1, ft_oe=0 for TURNAROUND_TICKS cycles, then -> IDLE.
//  Rules:
//   - At most one access in flight; ft_rdn and ft_wrn are never low together.
//   - ft_oe=0 whenever ft_rdn=0.
//   - ft_rxfn/ft_txen changes during READ/WRITE/TURN are ignored; the access completes.
//   - rx_ready or tx_valid dropping after IDLE does not abort the access; rx_ready
//     guaranteed one slot.
//   - Exactly one rx_valid per READ and one tx_rd per WRITE.
//   - Latency: ft_rxfn falling edge -> ft_rdn low = 3 cycles (2 sync + 1 FSM).
//   - Full access period, read:  READ_TICKS + 1 + TURNAROUND_TICKS cycles.
//   - Full access period, write: WRITE_TICKS + 2 + TURNAROUND_TICKS cycles.
//   - Counter width: $clog2(max(READ_TICKS, WRITE_TICKS + 1, TURNAROUND_TICKS) + 1).
// CONFIGURATION
//  FT245A_PHY_RR_ARB_EN defined:
//   - Round-robin arbitration; a 1-bit last_dir flag (reset = WRITE) grants the
//     opposite direction on a tie.
//  Not defined:
//   - Fixed priority; READ always wins a tie (TX can starve while RX streams).
//  The feature changes only the tie case.
// TESTING
//  Defaults throughout. The bench FT model drives ft_din on RD# fall and samples ft_dout on WR# rise.
//  1 Single read: ft_rxfn=0, rx_ready=1, ft_din=0xA5
//    -> ft_rdn low 4 cycles; rx_valid pulse with rx_data=0xA5; 8 turnaround cycles.
//  2 Single write: tx_valid=1, tx_data=0x3C, ft_txen=0
//    -> one tx_rd; ft_oe before WR# fall; WR# low 4 cycles; FT model captures 0x3C.
//  3 Back-pressure: rx_ready=0 with ft_rxfn=0 for 50 cycles
//    -> ft_rdn stays 1; raising rx_ready starts a read within 2 cycles.
//  4 Tie, 16 bytes each way with both requests held:
//    -> RR_ARB_EN: strict R/W alternation, 32 accesses.
//    -> Without it: all 16 reads precede any write.
//    -> Either way: byte streams intact, no overlap of ft_rdn=0 and ft_wrn=0.
//  5 Reset: ft_rst=0 asserted during the 2nd cycle of WR# low
//    -> ft_wrn=1 and ft_oe=0 immediately; after release the FSM is in IDLE and a
//       fresh write completes normally.
//  6 Stream 256 random bytes RX, READ_TICKS=1, TURNAROUND_TICKS=1
//    -> 256 rx_valid pulses, data in order, period 3 cycles.

Source files
------------

// File: rtl/ft245a_phy.sv
// FT245 asynchronous FIFO pin engine: RD#/WR# strobe timing, bus turnaround, RX push / TX pop.
// Optional FT245A_PHY_RR_ARB_EN selects round-robin tie arbitration (default: read wins ties).
`timescale 1ns/1ps
module ft245a_phy #(
  parameter int DATA_W           = 8,
  parameter int READ_TICKS       = 4,
  parameter int WRITE_TICKS      = 4,
  parameter int TURNAROUND_TICKS = 8
) (
  input  logic              ft_clk,
  input  logic              ft_rst,
  input  logic              ft_rxfn,
  input  logic              ft_txen,
  input  logic [DATA_W-1:0] ft_din,
  output logic [DATA_W-1:0] ft_dout,
  output logic              ft_oe,
  output logic              ft_rdn,
  output logic              ft_wrn,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_rd
);

  localparam int MAX_A = (READ_TICKS > WRITE_TICKS + 1) ? READ_TICKS : WRITE_TICKS + 1;
  localparam int MAX_T = (MAX_A > TURNAROUND_TICKS) ? MAX_A : TURNAROUND_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t RD_LOAD = cnt_t'(READ_TICKS - 1);
  localparam cnt_t WR_LOAD = cnt_t'(WRITE_TICKS);      // setup cycle + WRITE_TICKS low cycles
  localparam cnt_t TA_LOAD = cnt_t'(TURNAROUND_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;

  state_t r_state, w_state_nxt;
  cnt_t   r_cnt, w_cnt_nxt;
  logic   r_rxf_meta, r_rxf_s, r_txe_meta, r_txe_s;
  logic   w_rd_req, w_wr_req, w_tie_rd, w_grant_rd, w_grant_wr, w_cnt_zero;

  always_ff @(posedge ft_clk or negedge ft_rst) begin
    if (!ft_rst) begin
      r_rxf_meta <= 1'b1;
      r_rxf_s    <= 1'b1;
      r_txe_meta <= 1'b1;
      r_txe_s    <= 1'b1;
    end else begin
      r_rxf_meta <= ft_rxfn;
      r_rxf_s    <= r_rxf_meta;
      r_txe_meta <= ft_txen;
      r_txe_s    <= r_txe_meta;
    end
  end

  assign w_rd_req = ~r_rxf_s & rx_ready;
  assign w_wr_req = ~r_txe_s & tx_valid;

`ifdef FT245A_PHY_RR_ARB_EN
  logic r_last_wr;

  always_ff @(posedge ft_clk or negedge ft_rst) begin
    if (!ft_rst)
      r_last_wr <= 1'b1;
    else if (r_state == S_IDLE && (w_rd_req || w_wr_req))
      r_last_wr <= ~w_grant_rd;
  end

  assign w_tie_rd = r_last_wr;
`else
  assign w_tie_rd = 1'b1;
`endif

  assign w_grant_rd = w_rd_req & (~w_wr_req | w_tie_rd);
  assign w_grant_wr = w_wr_req & ~w_grant_rd;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge ft_clk or negedge ft_rst) begin
    if (!ft_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    tx_rd       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_rd) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = RD_LOAD;
        end else if (w_grant_wr) begin
          w_state_nxt = S_WRITE;
          w_cnt_nxt   = WR_LOAD;
          tx_rd       = 1'b1;
        end
      end
      S_READ, S_WRITE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_TURN;
          w_cnt_nxt   = TA_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      S_TURN: begin
        if (w_cnt_zero) w_state_nxt = S_IDLE;
        else            w_cnt_nxt   = r_cnt - cnt_t'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The write data-hold cycle overlaps the first TURN cycle: ft_oe drops at its end.
  always_ff @(posedge ft_clk or negedge ft_rst) begin
    if (!ft_rst) begin
      ft_rdn   <= 1'b1;
      ft_wrn   <= 1'b1;
      ft_oe    <= 1'b0;
      ft_dout  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_rd) begin
            ft_rdn <= 1'b0;
          end else if (w_grant_wr) begin
            ft_oe   <= 1'b1;
            ft_dout <= tx_data;
          end
        end
        S_READ: begin
          if (w_cnt_zero) begin
            rx_data  <= ft_din;
            rx_valid <= 1'b1;
            ft_rdn   <= 1'b1;
          end
        end
        S_WRITE: begin
          if (r_cnt == WR_LOAD) ft_wrn <= 1'b0;
          if (w_cnt_zero)       ft_wrn <= 1'b1;
        end
        S_TURN: begin
          ft_oe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ft245a_phy.sv
// Scoreboard bench for ft245a_phy: FT chip model + FIFO models, expected data queued at stimulus time.
`timescale 1ns/1ps
module tb_ft245a_phy;
  localparam int RT = 4, WT = 4, TT = 8;
  localparam int RT_B = 1, TT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // Instance A: default timing
  logic       rxfn_a = 1'b1, txen_a = 1'b1, rx_ready_a = 1'b1, tx_valid_a = 1'b0;
  logic [7:0] din_a = '0, tx_data_a = '0;
  logic [7:0] dout_a, rx_data_a;
  logic       oe_a, rdn_a, wrn_a, rx_valid_a, tx_rd_a;

  // Instance B: fast read stream
  logic       rxfn_b = 1'b1, txen_b = 1'b1, rx_ready_b = 1'b1, tx_valid_b = 1'b0;
  logic [7:0] din_b = '0, tx_data_b = '0;
  logic [7:0] dout_b, rx_data_b;
  logic       oe_b, rdn_b, wrn_b, rx_valid_b, tx_rd_b;

  ft245a_phy #(.DATA_W(8), .READ_TICKS(RT), .WRITE_TICKS(WT), .TURNAROUND_TICKS(TT)) dut_a (
    .ft_clk(clk), .ft_rst(rst_n), .ft_rxfn(rxfn_a), .ft_txen(txen_a), .ft_din(din_a),
    .ft_dout(dout_a), .ft_oe(oe_a), .ft_rdn(rdn_a), .ft_wrn(wrn_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_rd(tx_rd_a));

  ft245a_phy #(.DATA_W(8), .READ_TICKS(RT_B), .WRITE_TICKS(WT), .TURNAROUND_TICKS(TT_B)) dut_b (
    .ft_clk(clk), .ft_rst(rst_n), .ft_rxfn(rxfn_b), .ft_txen(txen_b), .ft_din(din_b),
    .ft_dout(dout_b), .ft_oe(oe_b), .ft_rdn(rdn_b), .ft_wrn(wrn_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_rd(tx_rd_b));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FT-side byte sources / expected sinks and TX FIFO model
  logic [7:0] rx_src_a[$], rx_exp_a[$], tx_fifo[$], tx_exp[$];
  logic [7:0] rx_src_b[$], rx_exp_b[$];
  logic [7:0] acc_log[$];
  logic       tx_en = 1'b0, lat_en = 1'b0, per_en = 1'b0, log_en = 1'b0;
  logic       pop_pend = 1'b0;
  int         pops = 0, prot_a = 0, prot_b = 0, nb_rx = 0;

  // Instance A: FT chip model + protocol monitor
  int   cyc_a = 0, rd_w = 0, wr_w = 0, rxfn_fall_cyc = 0, prev_start = 0, start;
  logic prev_rdn = 1'b1, prev_wrn = 1'b1, prev_oe = 1'b0, prev_is_rd = 1'b0, have_prev = 1'b0;
  logic new_rxfn;
  always @(negedge clk) begin
    cyc_a++;
    pop_pend = tx_rd_a;
    if (!rst_n) begin
      prev_rdn = 1'b1; prev_wrn = 1'b1; prev_oe = 1'b0; rd_w = 0; wr_w = 0;
    end else begin
      if (!rdn_a && !wrn_a) prot_a++;
      if (!rdn_a && oe_a) prot_a++;
      if (rx_valid_a && !(!prev_rdn && rdn_a)) prot_a++;
      if (!rdn_a) rd_w++;
      if (!wrn_a) wr_w++;
      if ((prev_rdn && !rdn_a) || (prev_wrn && !wrn_a)) begin
        start = cyc_a - ((!rdn_a) ? 1 : 2);
        if (per_en && have_prev)
          chk("access_period", start - prev_start, prev_is_rd ? RT + 1 + TT : WT + 2 + TT);
        prev_start = start;
        prev_is_rd = !rdn_a;
        have_prev  = per_en;
        if (log_en) acc_log.push_back(!rdn_a ? "R" : "W");
      end
      if (prev_rdn && !rdn_a) begin
        if (lat_en) chk("rd_latency", cyc_a - rxfn_fall_cyc, 3);
        if (rx_src_a.size() > 0) din_a = rx_src_a.pop_front();
        else prot_a++;
      end
      if (!prev_rdn && rdn_a) begin
        chk("rd_low_width", rd_w, RT);
        rd_w = 0;
      end
      if (prev_wrn && !wrn_a) chk("wr_oe_setup", prev_oe, 1);
      if (!prev_wrn && wrn_a) begin
        chk("wr_low_width", wr_w, WT);
        chk("wr_oe_hold", oe_a, 1);
        if (tx_exp.size() > 0) chk("ft_capture", dout_a, tx_exp.pop_front());
        else prot_a++;
        wr_w = 0;
      end
      if (rx_valid_a) begin
        if (rx_exp_a.size() > 0) chk("rx_data", rx_data_a, rx_exp_a.pop_front());
        else prot_a++;
      end
      prev_rdn = rdn_a; prev_wrn = wrn_a; prev_oe = oe_a;
    end
    new_rxfn = (rx_src_a.size() == 0);
    if (rxfn_a && !new_rxfn) rxfn_fall_cyc = cyc_a;
    rxfn_a = new_rxfn;
    txen_a = !tx_en;
  end

  // TX FIFO (show-ahead): pop on the edge following a sampled tx_rd
  always @(posedge clk) begin
    #1;
    if (pop_pend && rst_n) begin
      if (tx_fifo.size() > 0) void'(tx_fifo.pop_front());
      pops++;
    end
    tx_valid_a = (tx_fifo.size() > 0);
    tx_data_a  = (tx_fifo.size() > 0) ? tx_fifo[0] : 8'h00;
  end

  // Instance B: FT model + monitor
  int   cyc_b = 0, rdw_b = 0, prev_fall_b = 0;
  logic prev_rdn_b = 1'b1, have_b = 1'b0;
  always @(negedge clk) begin
    cyc_b++;
    if (!rst_n) begin
      prev_rdn_b = 1'b1; rdw_b = 0;
    end else begin
      if ((!rdn_b && oe_b) || !wrn_b || tx_rd_b) prot_b++;
      if (!rdn_b) rdw_b++;
      if (prev_rdn_b && !rdn_b) begin
        if (have_b) chk("b_period", cyc_b - prev_fall_b, RT_B + 1 + TT_B);
        prev_fall_b = cyc_b;
        have_b = 1'b1;
        if (rx_src_b.size() > 0) din_b = rx_src_b.pop_front();
        else prot_b++;
      end
      if (!prev_rdn_b && rdn_b) begin
        chk("b_rd_width", rdw_b, RT_B);
        rdw_b = 0;
      end
      if (rx_valid_b) begin
        nb_rx++;
        if (rx_exp_b.size() > 0) chk("b_rx_data", rx_data_b, rx_exp_b.pop_front());
        else prot_b++;
      end
      prev_rdn_b = rdn_b;
    end
    rxfn_b = (rx_src_b.size() == 0);
  end

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((rx_src_a.size() + rx_exp_a.size() + tx_fifo.size() + tx_exp.size()) > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, (rx_src_a.size() + rx_exp_a.size() + tx_fifo.size() + tx_exp.size()), 0);
    repeat (TT + 6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic [7:0] exp_seq[$];
    logic [7:0] last, d, got;
    int p0, k, low, r, w;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdn", rdn_a, 1);
    chk("rst_wrn", wrn_a, 1);
    chk("rst_oe", oe_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_rx_data", rx_data_a, 0);
    chk("rst_rx_valid", rx_valid_a, 0);
    chk("rst_tx_rd", tx_rd_a, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 1: single read
    lat_en = 1'b1;
    rx_src_a.push_back(8'hA5); rx_exp_a.push_back(8'hA5);
    wait_idle("t1_done", 200);
    lat_en = 1'b0;

    // 2: single write
    p0 = pops; tx_en = 1'b1;
    tx_fifo.push_back(8'h3C); tx_exp.push_back(8'h3C);
    wait_idle("t2_done", 200);
    chk("t2_tx_rd_count", pops - p0, 1);
    tx_en = 1'b0;

    // 3: back-pressure
    rx_ready_a = 1'b0;
    v = 8'($urandom);
    rx_src_a.push_back(v); rx_exp_a.push_back(v);
    low = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rdn_a) low++;
    end
    chk("t3_rdn_held", low, 0);
    @(posedge clk); #1;
    rx_ready_a = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rdn_a && k < 10);
    chk("t3_start_within_2", (k <= 2), 1);
    wait_idle("t3_done", 200);

    // 4: 16 bytes each way, both requests held; last access before this was a read
    last = "R"; r = 16; w = 16;
    while (r > 0 || w > 0) begin
`ifdef FT245A_PHY_RR_ARB_EN
      if (r > 0 && w > 0) d = (last == "R") ? "W" : "R";
      else d = (r > 0) ? "R" : "W";
`else
      d = (r > 0) ? "R" : "W";
`endif
      exp_seq.push_back(d);
      last = d;
      if (d == "R") r--; else w--;
    end
    acc_log.delete();
    per_en = 1'b1; log_en = 1'b1; p0 = pops;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom); rx_src_a.push_back(v); rx_exp_a.push_back(v);
      v = 8'($urandom); tx_fifo.push_back(v); tx_exp.push_back(v);
    end
    tx_en = 1'b1;
    wait_idle("t4_done", 3000);
    per_en = 1'b0; log_en = 1'b0; tx_en = 1'b0;
    chk("t4_access_count", acc_log.size(), 32);
    for (int i = 0; i < 32; i++) begin
      got = (i < acc_log.size()) ? acc_log[i] : 8'h00;
      chk($sformatf("t4_order[%0d]", i), got, exp_seq[i]);
    end
    chk("t4_tx_rd_count", pops - p0, 16);

    // 5: reset during the 2nd WR# low cycle, then a clean write
    p0 = pops; tx_en = 1'b1;
    tx_fifo.push_back(8'($urandom));
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (wrn_a && k < 100);
    chk("t5_wr_started", wrn_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wrn", wrn_a, 1);
    chk("t5_rst_oe", oe_a, 0);
    chk("t5_rst_rdn", rdn_a, 1);
    chk("t5_rst_dout", dout_a, 0);
    chk("t5_rst_rx_valid", rx_valid_a, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    v = 8'($urandom);
    tx_fifo.push_back(v); tx_exp.push_back(v);
    wait_idle("t5_done", 300);
    chk("t5_tx_rd_count", pops - p0, 2);
    tx_en = 1'b0;

    // 6: 256-byte RX stream on the fast instance
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      rx_src_b.push_back(v); rx_exp_b.push_back(v);
    end
    k = 0;
    while (rx_exp_b.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("t6_rx_valid_count", nb_rx, 256);
    chk("t6_queue_drained", rx_exp_b.size(), 0);

    chk("protocol_a", prot_a, 0);
    chk("protocol_b", prot_b, 0);
    chk("b_dout_idle", dout_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
